// File: rtl/alu_bus_master_if.sv
// alu_bus_master_if
// Groups the command, ALU-slave bus and response signals of the ALU bus
// master into one bundle.
//   master modport : the bus master's view (takes commands, drives the ALU
//                    slave operands/select/enable, reads the shared result
//                    bus, offers the response)
//   slave  modport : the ALU slave's view (reads operands/select/enable,
//                    drives the shared result bus)
// Signals:
//   cmd_valid/cmd_ready, cmd_op[2:0], cmd_a[7:0], cmd_b[7:0], cmd_chain
//   bus_a[7:0], bus_b[7:0], bus_sel[2:0], bus_en, bus_y[7:0]
//   rsp_valid/rsp_ready, rsp_data[7:0]
interface alu_bus_master_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic       cmd_chain;
  logic [7:0] bus_a;
  logic [7:0] bus_b;
  logic [2:0] bus_sel;
  logic       bus_en;
  logic [7:0] bus_y;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_ready;

  modport master (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_chain, bus_y, rsp_ready,
    output cmd_ready, bus_a, bus_b, bus_sel, bus_en, rsp_valid, rsp_data
  );

  modport slave (
    input  bus_a, bus_b, bus_sel, bus_en,
    output bus_y
  );
endinterface

// File: rtl/alu_bus_master.sv
// alu_bus_master
// Accepts one ALU command at a time, presents its operands and select code to
// an external ALU slave, enables the slave's tri-state result driver for
// SETTLE_CYCLES cycles, captures the shared result bus at the end of that
// window and offers it as a response.
// Ports:
//   clk        single clock, rising edge
//   rst        synchronous active-high reset
//   io         alu_bus_master_if.master (command, slave bus, response)
//   busy       high whenever the FSM is not idle
//   mismatch   sticky flag: captured result differed from the internal
//              model (only when ALU_MASTER_CHECK_EN is defined)
// Configuration macro: ALU_MASTER_CHECK_EN enables the internal result model
// and the mismatch output.
module alu_bus_master #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  alu_bus_master_if.master       io,
  output logic                   busy
`ifdef ALU_MASTER_CHECK_EN
  ,
  output logic                   mismatch
`endif
);

  typedef enum logic [1:0] {
    st_idle   = 2'd0,
    st_setup  = 2'd1,
    st_enable = 2'd2,
    st_resp   = 2'd3
  } state_t;

  // Counter value of the final enable cycle.
  localparam logic [3:0] last_cnt = 4'(SETTLE_CYCLES - 1);

  state_t     state_r;
  state_t     state_nxt_s;
  logic [3:0] cnt_r;
  logic [3:0] cnt_nxt_s;
  logic       accept_s;
  logic       capture_s;
  logic [7:0] operand_a_s;

  logic       cmd_ready_r;
  logic       bus_en_r;
  logic       rsp_valid_r;
  logic       busy_r;
  logic [7:0] bus_a_r;
  logic [7:0] bus_b_r;
  logic [2:0] bus_sel_r;
  logic [7:0] rsp_data_r;
  logic [7:0] last_r;

  // Chained commands take the previous captured result as operand A.
  assign operand_a_s = io.cmd_chain ? last_r : io.cmd_a;

  // Next-state, settle counter and handshake/capture strobes.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    accept_s    = 1'b0;
    capture_s   = 1'b0;
    case (state_r)
      st_idle: begin
        if (io.cmd_valid && cmd_ready_r) begin
          accept_s    = 1'b1;
          state_nxt_s = st_setup;
        end else begin
          state_nxt_s = st_idle;
        end
      end
      st_setup: begin
        state_nxt_s = st_enable;
        cnt_nxt_s   = 4'd0;
      end
      st_enable: begin
        if (cnt_r == last_cnt) begin
          capture_s   = 1'b1;
          state_nxt_s = st_resp;
          cnt_nxt_s   = 4'd0;
        end else begin
          cnt_nxt_s   = cnt_r + 4'd1;
        end
      end
      st_resp: begin
        if (io.rsp_ready) begin
          state_nxt_s = st_idle;
        end else begin
          state_nxt_s = st_resp;
        end
      end
      default: begin
        state_nxt_s = st_idle;
        cnt_nxt_s   = 4'd0;
      end
    endcase
  end

  // FSM state and settle counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= st_idle;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Registered outputs: status flags decode the upcoming state so they line
  // up with the state register; operands latch on accept, result on capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_ready_r <= 1'b1;
      bus_en_r    <= 1'b0;
      rsp_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      bus_a_r     <= 8'h00;
      bus_b_r     <= 8'h00;
      bus_sel_r   <= 3'b000;
      rsp_data_r  <= 8'h00;
      last_r      <= 8'h00;
    end else begin
      cmd_ready_r <= (state_nxt_s == st_idle);
      bus_en_r    <= (state_nxt_s == st_enable);
      rsp_valid_r <= (state_nxt_s == st_resp);
      busy_r      <= (state_nxt_s != st_idle);
      if (accept_s) begin
        bus_a_r   <= operand_a_s;
        bus_b_r   <= io.cmd_b;
        bus_sel_r <= io.cmd_op;
      end
      if (capture_s) begin
        rsp_data_r <= io.bus_y;
        last_r     <= io.bus_y;
      end
    end
  end

  assign io.cmd_ready = cmd_ready_r;
  assign io.bus_en    = bus_en_r;
  assign io.bus_a     = bus_a_r;
  assign io.bus_b     = bus_b_r;
  assign io.bus_sel   = bus_sel_r;
  assign io.rsp_valid = rsp_valid_r;
  assign io.rsp_data  = rsp_data_r;
  assign busy         = busy_r;

`ifdef ALU_MASTER_CHECK_EN
  logic mismatch_r;

  // Expected slave result for a select code; 8-bit wrap-around arithmetic.
  function automatic logic [7:0] alu_expect(input logic [2:0] op,
                                            input logic [7:0] a,
                                            input logic [7:0] b);
    logic [7:0] y;
    case (op)
      3'b000:  y = 8'h00;
      3'b001:  y = a & b;
      3'b010:  y = a | b;
      3'b011:  y = a ^ b;
      3'b100:  y = ~a;
      3'b101:  y = a - b;
      3'b110:  y = a + b;
      3'b111:  y = 8'hFF;
      default: y = 8'h00;
    endcase
    return y;
  endfunction

  // Sticky flag set when the captured bus value disagrees with the model.
  always_ff @(posedge clk) begin
    if (rst) begin
      mismatch_r <= 1'b0;
    end else if (capture_s && (io.bus_y != alu_expect(bus_sel_r, bus_a_r, bus_b_r))) begin
      mismatch_r <= 1'b1;
    end else begin
      mismatch_r <= mismatch_r;
    end
  end

  assign mismatch = mismatch_r;
`endif

endmodule

// File: tb/tb_alu_bus_master.sv
// tb_alu_bus_master
// Two masters (SETTLE_CYCLES 1 and 3), each with its own behavioural ALU
// slave. A directed vector table, hand-written reset/check sequences and a
// randomized run are checked cycle by cycle against an expected timeline
// derived from the operation's latency rules and a plain arithmetic ALU model.
module tb_alu_bus_master;
  localparam int S0 = 1;
  localparam int S1 = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_bus_master_if if0 ();
  alu_bus_master_if if1 ();

  logic       cv  [2];
  logic [2:0] cop [2];
  logic [7:0] ca  [2];
  logic [7:0] cb  [2];
  logic       cch [2];
  logic       rr  [2];
  logic       fb  [2];
  logic       busy0, busy1;
  logic       mm0, mm1;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] last_v [2];

  // Reference ALU behaviour straight from the select-code table.
  function automatic logic [7:0] ref_alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int r;
    case (op)
      3'd0: r = 0;
      3'd1: r = int'(a & b);
      3'd2: r = int'(a | b);
      3'd3: r = int'(a ^ b);
      3'd4: r = 255 - int'(a);
      3'd5: r = (int'(a) - int'(b) + 256) % 256;
      3'd6: r = (int'(a) + int'(b)) % 256;
      default: r = 255;
    endcase
    return 8'(r);
  endfunction

  assign if0.cmd_valid = cv[0];  assign if1.cmd_valid = cv[1];
  assign if0.cmd_op    = cop[0]; assign if1.cmd_op    = cop[1];
  assign if0.cmd_a     = ca[0];  assign if1.cmd_a     = ca[1];
  assign if0.cmd_b     = cb[0];  assign if1.cmd_b     = cb[1];
  assign if0.cmd_chain = cch[0]; assign if1.cmd_chain = cch[1];
  assign if0.rsp_ready = rr[0];  assign if1.rsp_ready = rr[1];
  // Slaves: drive the result only while enabled, otherwise a float pattern.
  assign if0.bus_y = if0.bus_en ? (fb[0] ? 8'hAA : ref_alu(if0.bus_sel, if0.bus_a, if0.bus_b)) : 8'h5A;
  assign if1.bus_y = if1.bus_en ? (fb[1] ? 8'hAA : ref_alu(if1.bus_sel, if1.bus_a, if1.bus_b)) : 8'h5A;

  alu_bus_master #(.SETTLE_CYCLES(S0)) dut0 (
    .clk(clk), .rst(rst), .io(if0.master), .busy(busy0)
`ifdef ALU_MASTER_CHECK_EN
    , .mismatch(mm0)
`endif
  );

  alu_bus_master #(.SETTLE_CYCLES(S1)) dut1 (
    .clk(clk), .rst(rst), .io(if1.master), .busy(busy1)
`ifdef ALU_MASTER_CHECK_EN
    , .mismatch(mm1)
`endif
  );

`ifndef ALU_MASTER_CHECK_EN
  assign mm0 = 1'b0;
  assign mm1 = 1'b0;
`endif

  typedef struct {
    logic       cr, en, rv, bz, mm;
    logic [7:0] a, b, rd;
    logic [2:0] sel;
  } snap_t;

  function automatic snap_t grab(input int d);
    snap_t s;
    if (d == 0) begin
      s.cr = if0.cmd_ready; s.en = if0.bus_en; s.rv = if0.rsp_valid; s.bz = busy0; s.mm = mm0;
      s.a = if0.bus_a; s.b = if0.bus_b; s.rd = if0.rsp_data; s.sel = if0.bus_sel;
    end else begin
      s.cr = if1.cmd_ready; s.en = if1.bus_en; s.rv = if1.rsp_valid; s.bz = busy1; s.mm = mm1;
      s.a = if1.bus_a; s.b = if1.bus_b; s.rd = if1.rsp_data; s.sel = if1.bus_sel;
    end
    return s;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic chk_reset_state(input int d);
    snap_t s;
    s = grab(d);
    chk($sformatf("rst_cmd_ready[%0d]", d), 32'(s.cr), 32'd1);
    chk($sformatf("rst_bus_en[%0d]", d), 32'(s.en), 32'd0);
    chk($sformatf("rst_bus_a[%0d]", d), 32'(s.a), 32'd0);
    chk($sformatf("rst_bus_b[%0d]", d), 32'(s.b), 32'd0);
    chk($sformatf("rst_bus_sel[%0d]", d), 32'(s.sel), 32'd0);
    chk($sformatf("rst_rsp_valid[%0d]", d), 32'(s.rv), 32'd0);
    chk($sformatf("rst_busy[%0d]", d), 32'(s.bz), 32'd0);
`ifdef ALU_MASTER_CHECK_EN
    chk($sformatf("rst_mismatch[%0d]", d), 32'(s.mm), 32'd0);
`endif
  endtask

  // One complete operation with a cycle-accurate expected timeline:
  // SETUP in cycle 1, bus_en in cycles 2..1+S, RESP from 2+S, handshake after
  // dly stalled RESP cycles. Command inputs carry junk while busy.
  task automatic do_op(input int d, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic ch, input int dly, input logic [7:0] exp_y);
    int s; int last_k; logic [7:0] exp_a; snap_t sn; logic en_e, rv_e;
    s = (d == 0) ? S0 : S1;
    exp_a = ch ? last_v[d] : a;
    last_k = 2 + s + dly;
    @(negedge clk);
    sn = grab(d);
    chk($sformatf("pre_cmd_ready[%0d]", d), 32'(sn.cr), 32'd1);
    cv[d] = 1'b1; cop[d] = op; ca[d] = a; cb[d] = b; cch[d] = ch; rr[d] = 1'($urandom_range(0, 1));
    @(posedge clk);
    for (int k = 1; k <= last_k; k++) begin
      @(negedge clk);
      sn = grab(d);
      en_e = (k >= 2) && (k <= 1 + s);
      rv_e = (k >= 2 + s);
      chk($sformatf("cmd_ready[%0d] k%0d", d, k), 32'(sn.cr), 32'd0);
      chk($sformatf("busy[%0d] k%0d", d, k), 32'(sn.bz), 32'd1);
      chk($sformatf("bus_en[%0d] k%0d", d, k), 32'(sn.en), 32'(en_e));
      chk($sformatf("rsp_valid[%0d] k%0d", d, k), 32'(sn.rv), 32'(rv_e));
      chk($sformatf("bus_a[%0d] k%0d", d, k), 32'(sn.a), 32'(exp_a));
      chk($sformatf("bus_b[%0d] k%0d", d, k), 32'(sn.b), 32'(b));
      chk($sformatf("bus_sel[%0d] k%0d", d, k), 32'(sn.sel), 32'(op));
      if (rv_e) chk($sformatf("rsp_data[%0d] k%0d", d, k), 32'(sn.rd), 32'(exp_y));
      cop[d] = 3'($urandom); ca[d] = 8'($urandom); cb[d] = 8'($urandom); cch[d] = 1'($urandom);
      cv[d] = (k == last_k) ? 1'b0 : 1'b1;
      rr[d] = (k >= 2 + s) ? (k == last_k) : 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    sn = grab(d);
    chk($sformatf("post_cmd_ready[%0d]", d), 32'(sn.cr), 32'd1);
    chk($sformatf("post_rsp_valid[%0d]", d), 32'(sn.rv), 32'd0);
    chk($sformatf("post_busy[%0d]", d), 32'(sn.bz), 32'd0);
    chk($sformatf("post_bus_en[%0d]", d), 32'(sn.en), 32'd0);
    chk($sformatf("post_bus_a_hold[%0d]", d), 32'(sn.a), 32'(exp_a));
    rr[d] = 1'b0;
    last_v[d] = exp_y;
  endtask

  typedef struct {
    int d; logic [2:0] op; logic [7:0] a, b; logic ch; int dly; logic [7:0] exp;
  } vec_t;

  vec_t vt [13];

  initial begin
    snap_t sn;
    vt[0]  = '{0, 3'b110, 8'h12, 8'h34, 1'b0, 0, 8'h46};
    vt[1]  = '{0, 3'b101, 8'h00, 8'h01, 1'b0, 0, 8'hFF};
    vt[2]  = '{0, 3'b110, 8'h77, 8'h01, 1'b1, 0, 8'h00};
    vt[3]  = '{1, 3'b110, 8'h99, 8'h07, 1'b1, 1, 8'h07};
    vt[4]  = '{1, 3'b110, 8'hFF, 8'h01, 1'b0, 5, 8'h00};
    vt[5]  = '{1, 3'b001, 8'h0F, 8'hF0, 1'b0, 1, 8'h00};
    vt[6]  = '{1, 3'b010, 8'h0F, 8'hF0, 1'b0, 0, 8'hFF};
    vt[7]  = '{1, 3'b011, 8'hAA, 8'hFF, 1'b0, 0, 8'h55};
    vt[8]  = '{0, 3'b100, 8'h3C, 8'h00, 1'b0, 0, 8'hC3};
    vt[9]  = '{0, 3'b000, 8'hFF, 8'hFF, 1'b0, 2, 8'h00};
    vt[10] = '{0, 3'b111, 8'h00, 8'h00, 1'b0, 0, 8'hFF};
    vt[11] = '{1, 3'b101, 8'h10, 8'h20, 1'b0, 2, 8'hF0};
    vt[12] = '{1, 3'b110, 8'h11, 8'h80, 1'b1, 0, 8'h70};

    for (int d = 0; d < 2; d++) begin
      cv[d] = 1'b0; cop[d] = 3'b000; ca[d] = 8'h00; cb[d] = 8'h00;
      cch[d] = 1'b0; rr[d] = 1'b0; fb[d] = 1'b0; last_v[d] = 8'h00;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_state(0);
    chk_reset_state(1);
    rst = 1'b0;

    // Directed vectors.
    for (int i = 0; i < 13; i++) begin
      do_op(vt[i].d, vt[i].op, vt[i].a, vt[i].b, vt[i].ch, vt[i].dly, vt[i].exp);
    end

    // Slave returns a wrong value: response carries the bus value, and the
    // check flag (when built in) sticks through later correct operations.
    fb[0] = 1'b1;
    do_op(0, 3'b001, 8'h0F, 8'hF0, 1'b0, 0, 8'hAA);
    fb[0] = 1'b0;
`ifdef ALU_MASTER_CHECK_EN
    sn = grab(0);
    chk("mismatch_set", 32'(sn.mm), 32'd1);
`endif
    do_op(0, 3'b110, 8'h01, 8'h02, 1'b0, 0, 8'h03);
    do_op(0, 3'b011, 8'h05, 8'h0F, 1'b1, 1, 8'h0C);
`ifdef ALU_MASTER_CHECK_EN
    sn = grab(0);
    chk("mismatch_sticky", 32'(sn.mm), 32'd1);
`endif

    // Reset during ENABLE of the slow master aborts the operation at once.
    @(negedge clk);
    cv[1] = 1'b1; cop[1] = 3'b110; ca[1] = 8'h21; cb[1] = 8'h12; cch[1] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cv[1] = 1'b0;
    @(negedge clk);
    sn = grab(1);
    chk("abort_pre_bus_en", 32'(sn.en), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    sn = grab(1);
    chk("abort_bus_en", 32'(sn.en), 32'd0);
    chk("abort_rsp_valid", 32'(sn.rv), 32'd0);
    chk("abort_cmd_ready", 32'(sn.cr), 32'd1);
    chk_reset_state(0);
    chk_reset_state(1);
    rst = 1'b0;
    last_v[0] = 8'h00;
    last_v[1] = 8'h00;
    repeat (3) @(negedge clk);
    sn = grab(1);
    chk("abort_no_rsp", 32'(sn.rv), 32'd0);
    do_op(1, 3'b110, 8'h99, 8'h05, 1'b1, 0, 8'h05);
    do_op(0, 3'b110, 8'h99, 8'hFE, 1'b1, 0, 8'hFE);

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      int d; logic [2:0] op; logic [7:0] a, b; logic ch;
      d  = $urandom_range(0, 1);
      op = 3'($urandom);
      a  = 8'($urandom);
      b  = 8'($urandom);
      ch = ($urandom_range(0, 3) == 0);
      do_op(d, op, a, b, ch, $urandom_range(0, 3), ref_alu(op, ch ? last_v[d] : a, b));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
